booth_mac_ctrl: RTL and testbench

Sequencer and accumulator directly upstream/downstream of the 8-bit radix-2 Booth multiplier; it drives the multiplier's reset/load/operand ports and consumes its 16-bit product.
- Accepts a stream of signed operand pairs over a valid/ready handshake and runs one multiplication per pair.
- Sign-extends each product and accumulates it.
- Emits the dot-product sum on an output handshake when the pair flagged last has been accumulated.

---
 rtl/booth_mac_ctrl_if.sv | 25 ++
 rtl/booth_mac_ctrl.sv | 112 +++++++++++
 tb/tb_booth_mac_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mac_ctrl_if.sv
// Operand-pair and result stream handshakes for booth_mac_ctrl.
// The controller takes the slave side; producer/consumer take master.
interface booth_mac_ctrl_if #(
    parameter int ACC_W = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             in_last;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_ready;
    logic             acc_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, acc_ready,
        input  in_ready, acc_out, acc_valid, acc_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, acc_ready,
        output in_ready, acc_out, acc_valid, acc_ovf
    );
endinterface

// File: rtl/booth_mac_ctrl.sv
// Sequencer/accumulator around an 8-bit radix-2 Booth multiplier.
// MAC_SAT_EN: saturate the accumulator on signed overflow instead of wrapping.
module booth_mac_ctrl #(
    parameter int ACC_W      = 24,
    parameter int RUN_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    booth_mac_ctrl_if.slave       bus,
    output logic                  mult_rst,
    output logic                  mult_load,
    output logic [7:0]            mult_multiplier,
    output logic [7:0]            mult_multiplicand,
    input  logic [15:0]           mult_result
);

    localparam int CNT_W = $clog2(RUN_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        MRST,
        LOAD,
        RUN,
        ACC,
        OUT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] acc_nxt;
    logic             last_q;
    logic             ovf_q;
    logic             ovf_det;

    assign bus.in_ready  = (state == IDLE);
    assign bus.acc_valid = (state == OUT);
    assign bus.acc_out   = acc;
    assign bus.acc_ovf   = ovf_q;
    assign mult_rst      = (state == MRST);
    assign mult_load     = (state == LOAD);

    assign addend  = ACC_W'($signed(mult_result));
    assign sum     = acc + addend;
    assign ovf_det = (acc[ACC_W-1] == addend[ACC_W-1]) &&
                     (sum[ACC_W-1] != acc[ACC_W-1]);

    always_comb begin
        acc_nxt = sum;
`ifdef MAC_SAT_EN
        // Clamp toward the side the addend was pushing.
        if (ovf_det) begin
            acc_nxt = addend[ACC_W-1] ?
                      {1'b1, {(ACC_W-1){1'b0}}} :
                      {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.in_valid) state_nxt = MRST;
            MRST: state_nxt = LOAD;
            LOAD: state_nxt = RUN;
            RUN:  if (cnt == CNT_W'(1)) state_nxt = ACC;
            ACC:  state_nxt = last_q ? OUT : IDLE;
            OUT:  if (bus.acc_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= IDLE;
            cnt               <= '0;
            acc               <= '0;
            ovf_q             <= 1'b0;
            last_q            <= 1'b0;
            mult_multiplier   <= '0;
            mult_multiplicand <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mult_multiplier   <= bus.in_a;
                        mult_multiplicand <= bus.in_b;
                        last_q            <= bus.in_last;
                    end
                end
                LOAD: cnt <= CNT_W'(RUN_CYCLES);
                RUN:  cnt <= cnt - CNT_W'(1);
                ACC: begin
                    acc <= acc_nxt;
                    if (ovf_det) ovf_q <= 1'b1;
                end
                OUT: begin
                    if (bus.acc_ready) begin
                        acc   <= '0;
                        ovf_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mac_ctrl.sv
// Directed bench for booth_mac_ctrl: vector table plus multi-cycle sequences.
// Expected overflow results follow MAC_SAT_EN when it is defined.
module tb_booth_mac_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    booth_mac_ctrl_if #(.ACC_W(24)) b24 ();
    booth_mac_ctrl_if #(.ACC_W(16)) b16 ();

    logic        m24_rst, m24_load;
    logic [7:0]  m24_a, m24_b;
    logic [15:0] m24_res;
    logic        m16_rst, m16_load;
    logic [7:0]  m16_a, m16_b;
    logic [15:0] m16_res;

    // Behavioural stand-in for the multiplier's final product.
    assign m24_res = {{8{m24_a[7]}}, m24_a} * {{8{m24_b[7]}}, m24_b};
    assign m16_res = {{8{m16_a[7]}}, m16_a} * {{8{m16_b[7]}}, m16_b};

    booth_mac_ctrl #(.ACC_W(24), .RUN_CYCLES(8)) u24 (
        .clk               (clk),
        .reset             (reset),
        .bus               (b24),
        .mult_rst          (m24_rst),
        .mult_load         (m24_load),
        .mult_multiplier   (m24_a),
        .mult_multiplicand (m24_b),
        .mult_result       (m24_res)
    );

    booth_mac_ctrl #(.ACC_W(16), .RUN_CYCLES(8)) u16 (
        .clk               (clk),
        .reset             (reset),
        .bus               (b16),
        .mult_rst          (m16_rst),
        .mult_load         (m16_load),
        .mult_multiplier   (m16_a),
        .mult_multiplicand (m16_b),
        .mult_result       (m16_res)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        last;
        logic [23:0] exp_acc;
        logic        exp_ovf;
    } vec_t;

    vec_t tab [7];
    int   pass_cnt = 0;
    int   total    = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send24(logic [7:0] a, logic [7:0] b, logic last);
        int w = 0;
        while (!b24.in_ready && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) check("ready24_timeout", 0, 1);
        b24.in_a     = a;
        b24.in_b     = b;
        b24.in_last  = last;
        b24.in_valid = 1'b1;
        tick();
        b24.in_valid = 1'b0;
    endtask

    task automatic run16(logic [7:0] a, logic [7:0] b, logic last);
        int w = 0;
        while (!b16.in_ready && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) check("ready16_timeout", 0, 1);
        b16.in_a     = a;
        b16.in_b     = b;
        b16.in_last  = last;
        b16.in_valid = 1'b1;
        tick();
        b16.in_valid = 1'b0;
        repeat (11) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lowc;
        int stable;
        logic [15:0] exp16;

        // a, b, last, acc after this pair, ovf
        tab[0] = '{8'h03, 8'h04, 1'b1, 24'h00000C, 1'b0};
        tab[1] = '{8'hFB, 8'h07, 1'b0, 24'hFFFFDD, 1'b0};
        tab[2] = '{8'h02, 8'h03, 1'b0, 24'hFFFFE3, 1'b0};
        tab[3] = '{8'h0A, 8'hFF, 1'b1, 24'hFFFFD9, 1'b0};
        tab[4] = '{8'h80, 8'h80, 1'b1, 24'h004000, 1'b0};
        tab[5] = '{8'hF9, 8'hF7, 1'b0, 24'h00003F, 1'b0};
        tab[6] = '{8'h00, 8'h64, 1'b1, 24'h00003F, 1'b0};

        reset = 1'b0;
        b24.in_valid = 1'b0; b24.in_a = '0; b24.in_b = '0;
        b24.in_last = 1'b0; b24.acc_ready = 1'b0;
        b16.in_valid = 1'b0; b16.in_a = '0; b16.in_b = '0;
        b16.in_last = 1'b0; b16.acc_ready = 1'b0;

        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("rst_in_ready", b24.in_ready, 1);
        check("rst_acc_valid", b24.acc_valid, 0);
        check("rst_acc_out", b24.acc_out, 0);
        check("rst_mult_rst", m24_rst, 0);
        check("rst_mult_load", m24_load, 0);
        check("rst_acc_ovf", b24.acc_ovf, 0);

        b24.acc_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send24(tab[i].a, tab[i].b, tab[i].last);
            lowc = 0;
            check($sformatf("v%0d_mult_rst", i), m24_rst, 1);
            check($sformatf("v%0d_opa", i), m24_a, tab[i].a);
            check($sformatf("v%0d_opb", i), m24_b, tab[i].b);
            if (!b24.in_ready) lowc++;
            tick();
            check($sformatf("v%0d_mult_load", i), m24_load, 1);
            if (!b24.in_ready) lowc++;
            for (int k = 2; k <= 10; k++) begin
                tick();
                if (!b24.in_ready) lowc++;
            end
            tick();
            check($sformatf("v%0d_busy", i), lowc, 11);
            check($sformatf("v%0d_acc", i), b24.acc_out, tab[i].exp_acc);
            check($sformatf("v%0d_ovf", i), b24.acc_ovf, tab[i].exp_ovf);
            if (tab[i].last) begin
                check($sformatf("v%0d_valid", i), b24.acc_valid, 1);
                check($sformatf("v%0d_ready_out", i), b24.in_ready, 0);
                tick();
                check($sformatf("v%0d_drain_rdy", i), b24.in_ready, 1);
                check($sformatf("v%0d_drain_acc", i), b24.acc_out, 0);
            end else begin
                check($sformatf("v%0d_ready", i), b24.in_ready, 1);
                check($sformatf("v%0d_novalid", i), b24.acc_valid, 0);
            end
        end

        // Backpressure in OUT
        b24.acc_ready = 1'b0;
        send24(8'h01, 8'h02, 1'b1);
        repeat (11) tick();
        stable = 0;
        for (int k = 0; k < 5; k++) begin
            if (b24.acc_valid && !b24.in_ready && b24.acc_out == 24'd2)
                stable++;
            if (k < 4) tick();
        end
        check("bp_stable", stable, 5);
        b24.acc_ready = 1'b1;
        tick();
        check("bp_idle", b24.in_ready, 1);
        check("bp_valid", b24.acc_valid, 0);
        check("bp_acc", b24.acc_out, 0);

        // Reset in RUN of the second pair discards the partial sum
        send24(8'h04, 8'h05, 1'b0);
        repeat (11) tick();
        check("pr_partial", b24.acc_out, 24'd20);
        send24(8'h02, 8'h02, 1'b0);
        repeat (4) tick();
        check("pr_in_run", b24.in_ready, 0);
        reset = 1'b0;
        tick();
        check("pr_rst_ready", b24.in_ready, 1);
        check("pr_rst_acc", b24.acc_out, 0);
        check("pr_rst_valid", b24.acc_valid, 0);
        check("pr_rst_mrst", m24_rst, 0);
        check("pr_rst_load", m24_load, 0);
        check("pr_rst_opa", m24_a, 0);
        reset = 1'b1;
        send24(8'h06, 8'h06, 1'b1);
        repeat (11) tick();
        check("pr_valid", b24.acc_valid, 1);
        check("pr_acc", b24.acc_out, 24'd36);
        tick();

        // 16-bit accumulator: positive overflow, stickiness
        b16.acc_ready = 1'b0;
        run16(8'h7F, 8'h7F, 1'b0);
        run16(8'h7F, 8'h7F, 1'b0);
        check("o16_acc2", b16.acc_out, 16'h7E02);
        check("o16_ovf2", b16.acc_ovf, 0);
        run16(8'h7F, 8'h7F, 1'b0);
`ifdef MAC_SAT_EN
        exp16 = 16'h7FFF;
`else
        exp16 = 16'hBD03;
`endif
        check("o16_acc3", b16.acc_out, exp16);
        check("o16_ovf3", b16.acc_ovf, 1);
        run16(8'h01, 8'h01, 1'b1);
`ifdef MAC_SAT_EN
        exp16 = 16'h7FFF;
`else
        exp16 = 16'hBD04;
`endif
        check("o16_valid", b16.acc_valid, 1);
        check("o16_acc4", b16.acc_out, exp16);
        check("o16_sticky", b16.acc_ovf, 1);
        b16.acc_ready = 1'b1;
        tick();
        check("o16_clr_ovf", b16.acc_ovf, 0);
        check("o16_clr_acc", b16.acc_out, 0);

        // 16-bit accumulator: negative overflow
        run16(8'h80, 8'h7F, 1'b0);
        run16(8'h80, 8'h7F, 1'b0);
        check("n16_acc2", b16.acc_out, 16'h8100);
        run16(8'h80, 8'h7F, 1'b1);
`ifdef MAC_SAT_EN
        exp16 = 16'h8000;
`else
        exp16 = 16'h4180;
`endif
        check("n16_acc3", b16.acc_out, exp16);
        check("n16_ovf", b16.acc_ovf, 1);
        tick();
        check("n16_drain", b16.in_ready, 1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
